// File: rtl/brick_renderer.sv
// Row-major scanner over the brick health store; issues one draw request per live brick.
// Optional BRICK_CLEAR_EN: empty cells are also drawn, in background colour, to erase them.
module brick_renderer #(
  parameter int COLS    = 16,
  parameter int ROWS    = 8,
  parameter int BRICK_W = 20,
  parameter int BRICK_H = 10,
  parameter int X0      = 0,
  parameter int Y0      = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [9:0] mem_x,
  output logic [9:0] mem_y,
  input  logic [1:0] mem_health,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [9:0] draw_x,
  output logic [9:0] draw_y,
  output logic [2:0] draw_colour
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CHECK, S_REQ, S_NEXT, S_DONE
  } state_t;

  state_t     state;
  logic [9:0] col, row;
  logic       last_col, last_row;
  logic [9:0] next_col, next_row;

  assign last_col = (col == 10'(COLS - 1));
  assign last_row = (row == 10'(ROWS - 1));
  assign next_col = last_col ? 10'd0 : col + 10'd1;
  assign next_row = last_col ? row + 10'd1 : row;

  function automatic logic [2:0] colour_of(input logic [1:0] health);
    case (health)
      2'd1:    return 3'b100;
      2'd2:    return 3'b110;
      2'd3:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_x       <= '0;
      mem_y       <= '0;
      draw_req    <= 1'b0;
      draw_x      <= '0;
      draw_y      <= '0;
      draw_colour <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ADDR;
            busy  <= 1'b1;
            mem_x <= col;
            mem_y <= row;
          end
        end
        S_ADDR:  state <= S_WAIT;
        // Memory has two edges of read latency; health is valid in CHECK.
        S_WAIT:  state <= S_CHECK;
        S_CHECK: begin
`ifdef BRICK_CLEAR_EN
          draw_x      <= 10'(X0 + BRICK_W * int'(col));
          draw_y      <= 10'(Y0 + BRICK_H * int'(row));
          draw_colour <= colour_of(mem_health);
          draw_req    <= 1'b1;
          state       <= S_REQ;
`else
          if (mem_health != 2'd0) begin
            draw_x      <= 10'(X0 + BRICK_W * int'(col));
            draw_y      <= 10'(Y0 + BRICK_H * int'(row));
            draw_colour <= colour_of(mem_health);
            draw_req    <= 1'b1;
            state       <= S_REQ;
          end else begin
            state <= S_NEXT;
          end
`endif
        end
        S_REQ: begin
          if (draw_ack) begin
            draw_req <= 1'b0;
            state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (last_col && last_row) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            col   <= next_col;
            row   <= next_row;
            mem_x <= next_col;
            mem_y <= next_row;
            state <= S_ADDR;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          col   <= '0;
          row   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_renderer.sv
// Directed bench for brick_renderer: a 2x2 instance and a default-size instance,
// each fed by a two-edge-latency brick memory model.
module tb_brick_renderer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Small 2x2 instance
  logic       s_start, s_busy, s_done, s_req, s_ack;
  logic [9:0] s_mem_x, s_mem_y, s_dx, s_dy;
  logic [1:0] s_health;
  logic [2:0] s_col;
  logic [1:0] s_mem [4];
  logic [1:0] s_addr_q;

  // Default 16x8 instance
  logic       b_start, b_busy, b_done, b_req, b_ack;
  logic [9:0] b_mem_x, b_mem_y, b_dx, b_dy;
  logic [1:0] b_health;
  logic [2:0] b_col;
  logic [1:0] b_mem [128];
  logic [6:0] b_addr_q;

  brick_renderer #(.COLS(2), .ROWS(2)) u_small (
    .clk(clk), .resetn(resetn), .start(s_start), .busy(s_busy), .done(s_done),
    .mem_x(s_mem_x), .mem_y(s_mem_y), .mem_health(s_health),
    .draw_req(s_req), .draw_ack(s_ack), .draw_x(s_dx), .draw_y(s_dy), .draw_colour(s_col)
  );

  brick_renderer u_big (
    .clk(clk), .resetn(resetn), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_x(b_mem_x), .mem_y(b_mem_y), .mem_health(b_health),
    .draw_req(b_req), .draw_ack(b_ack), .draw_x(b_dx), .draw_y(b_dy), .draw_colour(b_col)
  );

  // Address registered on one edge, data on the next.
  always @(posedge clk) begin
    s_addr_q <= {s_mem_y[0], s_mem_x[0]};
    s_health <= s_mem[s_addr_q];
    b_addr_q <= {b_mem_y[2:0], b_mem_x[3:0]};
    b_health <= b_mem[b_addr_q];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  int         busy_cnt, done_cnt, done_at, req_cnt;
  logic [2:0] rc [8];
  logic [9:0] rx [8];

  initial begin
    resetn  = 1'b0;
    s_start = 1'b0; s_ack = 1'b1;
    b_start = 1'b0; b_ack = 1'b0;
    for (int i = 0; i < 4; i++)   s_mem[i] = 2'd0;
    for (int i = 0; i < 128; i++) b_mem[i] = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",   {31'd0, s_busy | b_busy}, 32'd0);
    check("rst_done",   {31'd0, s_done | b_done}, 32'd0);
    check("rst_req",    {31'd0, s_req | b_req},   32'd0);
    check("rst_mem_xy", {12'd0, b_mem_x, b_mem_y}, 32'd0);
    check("rst_colour", {26'd0, s_col, b_col},     32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Small grid full scan; a second start mid-scan must be ignored
`ifdef BRICK_CLEAR_EN
    s_mem[1] = 2'd1;
`endif
    busy_cnt = 0; done_cnt = 0; done_at = 0; req_cnt = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_busy) busy_cnt++;
      if (s_done) begin done_cnt++; done_at = busy_cnt; end
      if (s_req) begin
        if (req_cnt < 8) begin rc[req_cnt] = s_col; rx[req_cnt] = s_dx; end
        req_cnt++;
      end
      s_start = (i == 5);
      @(negedge clk);
    end
    s_start = 1'b0;
`ifdef BRICK_CLEAR_EN
    check("small_busy_cycles", busy_cnt, 32'd21);
    check("small_done_pos",    done_at,  32'd21);
    check("small_req_count",   req_cnt,  32'd4);
    check("small_colours",     {20'd0, rc[0], rc[1], rc[2], rc[3]}, {20'd0, 3'b000, 3'b100, 3'b000, 3'b000});
    check("small_x1",          rx[1], 32'd20);
`else
    check("small_busy_cycles", busy_cnt, 32'd17);
    check("small_done_pos",    done_at,  32'd17);
    check("small_req_count",   req_cnt,  32'd0);
`endif
    check("small_done_count", done_cnt, 32'd1);
    check("small_idle_after", {31'd0, s_busy}, 32'd0);

`ifndef BRICK_CLEAR_EN
    // Single brick at (3,1), health 2, ack held off 5 cycles
    b_mem[19] = 2'd2;
    b_ack = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 0; k < 2000 && !b_req; k++) @(negedge clk);
    check("one_req_seen", {31'd0, b_req}, 32'd1);
    check("one_req_xyc",  {9'd0, b_dx, b_dy, b_col}, {9'd0, 10'd60, 10'd10, 3'b110});
    check("one_req_addr", {12'd0, b_mem_x, b_mem_y}, {12'd0, 10'd3, 10'd1});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("one_req_stable", {8'd0, b_req, b_dx, b_dy, b_col}, {8'd0, 1'b1, 10'd60, 10'd10, 3'b110});
    end
    b_ack = 1'b1;
    @(negedge clk);
    b_ack = 1'b0;
    check("one_req_drop", {31'd0, b_req}, 32'd0);
    req_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      if (b_req) req_cnt++;
      if (b_done) done_cnt++;
      @(negedge clk);
    end
    check("one_done",       done_cnt, 32'd1);
    check("one_extra_reqs", req_cnt,  32'd0);
    check("one_idle_after", {31'd0, b_busy}, 32'd0);

    // Colour map with ack tied high
    b_mem[19] = 2'd0;
    b_mem[0] = 2'd1; b_mem[1] = 2'd2; b_mem[2] = 2'd3;
    b_ack = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    req_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      if (b_req) begin
        if (req_cnt < 8) begin rc[req_cnt] = b_col; rx[req_cnt] = b_dx; end
        req_cnt++;
      end
      if (b_done) done_cnt++;
      @(negedge clk);
    end
    check("cmap_done",    done_cnt, 32'd1);
    check("cmap_count",   req_cnt,  32'd3);
    check("cmap_colours", {23'd0, rc[0], rc[1], rc[2]}, {23'd0, 3'b100, 3'b110, 3'b010});
    check("cmap_x",       {2'd0, rx[0], rx[1], rx[2]}, {2'd0, 10'd0, 10'd20, 10'd40});

    // Reset asserted while a request is pending
    b_mem[0] = 2'd0; b_mem[1] = 2'd0; b_mem[2] = 2'd0; b_mem[19] = 2'd2;
    b_ack = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 0; k < 2000 && !b_req; k++) @(negedge clk);
    check("abort_req_seen", {31'd0, b_req}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("abort_req_async", {31'd0, b_req}, 32'd0);
    check("abort_busy",      {31'd0, b_busy}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b_done) done_cnt++;
      if (b_busy) busy_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_idle",    busy_cnt, 32'd0);
    b_ack = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("rescan_addr", {11'd0, b_busy, b_mem_x, b_mem_y}, {11'd0, 1'b1, 10'd0, 10'd0});
    req_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
      if (b_req) begin
        if (req_cnt < 8) rx[req_cnt] = b_dx;
        req_cnt++;
      end
      if (b_done) done_cnt++;
      @(negedge clk);
    end
    check("rescan_done", done_cnt, 32'd1);
    check("rescan_req",  {22'd0, rx[0]}, 32'd60);
    check("rescan_count", req_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
